// File: rtl/ball_pkg.sv
// Shared constants for the billiard ball kinematics: table geometry, speed limit,
// direction encodings and FSM state codes.
package ball_pkg;

    localparam int BALL_R = 12;
    localparam int BALL_D = 24;

    localparam int XMIN = 20;
    localparam int XMAX = 620;
    localparam int YMIN = 20;
    localparam int YMAX = 460;

    localparam int VMAX = 12;

    // Directions are stored as 10-bit two's complement +1 / -1.
    localparam logic [9:0] DIR_POS = 10'h001;
    localparam logic [9:0] DIR_NEG = 10'h3FF;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MOVE = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    // Any negative direction request means -1, everything else +1.
    function automatic logic [9:0] dir_decode(input logic neg);
        return neg ? DIR_NEG : DIR_POS;
    endfunction

    function automatic logic [9:0] sat_speed(input logic [9:0] v, input logic [9:0] vmax);
        return (v > vmax) ? vmax : v;
    endfunction

endpackage

// File: rtl/axis_step.sv
// One axis of a frame step: position advance, cushion reflection with direction
// flip, and the friction decrement of that axis' speed.
module axis_step
    import ball_pkg::*;
#(
    parameter int MIN = 20,
    parameter int MAX = 620,
    parameter int RAD = 12
) (
    input  logic [9:0] p_i,
    input  logic [9:0] v_i,
    input  logic [9:0] d_i,
    input  logic       fric_wrap_i,
    output logic [9:0] p_o,
    output logic [9:0] v_o,
    output logic [9:0] d_o
);

    // 12 bits so the doubled limits (up to ~1216) never wrap.
    localparam logic signed [11:0] HI_S  = 12'(MAX - RAD);
    localparam logic signed [11:0] LO_S  = 12'(MIN + RAD);
    localparam logic signed [11:0] HI2_S = 12'(2 * (MAX - RAD));
    localparam logic signed [11:0] LO2_S = 12'(2 * (MIN + RAD));

    logic signed [11:0] delta;
    logic signed [11:0] p_n;
    logic signed [11:0] p_res;
    logic               unused_p_hi;

    // Advance, then fold any overshoot back inside the cushion and flip direction.
    always_comb begin
        delta = d_i[9] ? -$signed({2'b00, v_i}) : $signed({2'b00, v_i});
        p_n   = $signed({2'b00, p_i}) + delta;
        p_res = p_n;
        d_o   = d_i;
        if (p_n > HI_S) begin
            p_res = HI2_S - p_n;
            d_o   = DIR_NEG;
        end else if (p_n < LO_S) begin
            p_res = LO2_S - p_n;
            d_o   = DIR_POS;
        end
        p_o = p_res[9:0];
    end

    // Friction takes one unit off a nonzero speed on the wrap frame.
    always_comb begin
        v_o = v_i;
        if (fric_wrap_i && (v_i != 10'd0)) begin
            v_o = v_i - 10'd1;
        end
    end

    assign unused_p_hi = ^p_res[11:10];

endmodule

// File: rtl/ball_motion.sv
// Per-ball kinematics: holds position/speed/direction, steps once per frame,
// accepts cue shots and post-collision velocity loads.
module ball_motion
    import ball_pkg::*;
#(
    parameter int X_INIT      = 100,
    parameter int Y_INIT      = 200,
    parameter int BALL_R      = ball_pkg::BALL_R,
    parameter int XMIN        = ball_pkg::XMIN,
    parameter int XMAX        = ball_pkg::XMAX,
    parameter int YMIN        = ball_pkg::YMIN,
    parameter int YMAX        = ball_pkg::YMAX,
    parameter int VMAX        = ball_pkg::VMAX,
    parameter int FRIC_PERIOD = 8,
    parameter int COLL_HOLD   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       shot_valid,
    output logic       shot_ready,
    input  logic [9:0] shot_vx,
    input  logic [9:0] shot_vy,
    input  logic [9:0] shot_dx,
    input  logic [9:0] shot_dy,
    input  logic       coll_in,
    input  logic [9:0] coll_vx,
    input  logic [9:0] coll_vy,
    input  logic [9:0] coll_dx,
    input  logic [9:0] coll_dy,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic [9:0] vx,
    output logic [9:0] vy,
    output logic [9:0] dx,
    output logic [9:0] dy,
    output logic       moving
);

    localparam int FW = (FRIC_PERIOD > 2) ? $clog2(FRIC_PERIOD) : 1;
    localparam int HW = (COLL_HOLD > 0) ? $clog2(COLL_HOLD + 1) : 1;
    localparam logic [9:0] VMAX_V = 10'(VMAX);

    logic [1:0]    state_q, state_d;
    logic [9:0]    x_q, x_d, y_q, y_d;
    logic [9:0]    vx_q, vx_d, vy_q, vy_d;
    logic [9:0]    dx_q, dx_d, dy_q, dy_d;
    logic [FW-1:0] fric_q, fric_d;
    logic [HW-1:0] hold_q, hold_d;

    logic          coll_acc, shot_acc, step, fric_wrap;
    logic [9:0]    cvx_abs, cvy_abs;
    logic [9:0]    ax_p, ax_v, ax_d, ay_p, ay_v, ay_d;
    logic          unused_dir_lo;

    assign shot_ready = (state_q == IDLE) & ~coll_in;
    assign coll_acc   = coll_in & (state_q != HOLD);
    assign shot_acc   = shot_valid & shot_ready;
    assign step       = frame_tick & (state_q != IDLE) & ~coll_acc;
    assign fric_wrap  = (fric_q == FW'(FRIC_PERIOD - 1));

    assign cvx_abs = coll_vx[9] ? (~coll_vx + 10'd1) : coll_vx;
    assign cvy_abs = coll_vy[9] ? (~coll_vy + 10'd1) : coll_vy;

    // Only the sign bit of a direction request matters.
    assign unused_dir_lo = ^{shot_dx[8:0], shot_dy[8:0], coll_dx[8:0], coll_dy[8:0]};

    axis_step #(
        .MIN(XMIN),
        .MAX(XMAX),
        .RAD(BALL_R)
    ) u_axis_x (
        .p_i        (x_q),
        .v_i        (vx_q),
        .d_i        (dx_q),
        .fric_wrap_i(fric_wrap),
        .p_o        (ax_p),
        .v_o        (ax_v),
        .d_o        (ax_d)
    );

    axis_step #(
        .MIN(YMIN),
        .MAX(YMAX),
        .RAD(BALL_R)
    ) u_axis_y (
        .p_i        (y_q),
        .v_i        (vy_q),
        .d_i        (dy_q),
        .fric_wrap_i(fric_wrap),
        .p_o        (ay_p),
        .v_o        (ay_v),
        .d_o        (ay_d)
    );

    // Next state: collision load beats shot load beats frame step.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        vx_d    = vx_q;
        vy_d    = vy_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        fric_d  = fric_q;
        hold_d  = hold_q;
        if (coll_acc) begin
            vx_d    = sat_speed(cvx_abs, VMAX_V);
            vy_d    = sat_speed(cvy_abs, VMAX_V);
            dx_d    = dir_decode(coll_dx[9]);
            dy_d    = dir_decode(coll_dy[9]);
            fric_d  = '0;
            hold_d  = HW'(COLL_HOLD);
            state_d = HOLD;
        end else if (shot_acc) begin
            vx_d    = sat_speed(shot_vx, VMAX_V);
            vy_d    = sat_speed(shot_vy, VMAX_V);
            dx_d    = dir_decode(shot_dx[9]);
            dy_d    = dir_decode(shot_dy[9]);
            fric_d  = '0;
            state_d = ((vx_d != 10'd0) || (vy_d != 10'd0)) ? MOVE : IDLE;
        end else if (step) begin
            x_d    = ax_p;
            y_d    = ay_p;
            vx_d   = ax_v;
            vy_d   = ay_v;
            dx_d   = ax_d;
            dy_d   = ay_d;
            fric_d = fric_wrap ? '0 : fric_q + FW'(1);
            if (state_q == HOLD) begin
                hold_d = hold_q - HW'(1);
                if (hold_d == '0) begin
                    state_d = ((ax_v == 10'd0) && (ay_v == 10'd0)) ? IDLE : MOVE;
                end
            end else if ((ax_v == 10'd0) && (ay_v == 10'd0)) begin
                state_d = IDLE;
            end
        end
    end

    // State registers with asynchronous reset to the rack position at rest.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            x_q     <= 10'(X_INIT);
            y_q     <= 10'(Y_INIT);
            vx_q    <= 10'd0;
            vy_q    <= 10'd0;
            dx_q    <= DIR_POS;
            dy_q    <= DIR_POS;
            fric_q  <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            vx_q    <= vx_d;
            vy_q    <= vy_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            fric_q  <= fric_d;
            hold_q  <= hold_d;
        end
    end

    assign x      = x_q;
    assign y      = y_q;
    assign vx     = vx_q;
    assign vy     = vy_q;
    assign dx     = dx_q;
    assign dy     = dy_q;
    assign moving = (state_q != IDLE);

endmodule

// File: tb/tb_ball_motion.sv
// Directed bench for ball_motion: reset, shot motion, friction, cushion bounce,
// collision priority and hold-off, stop and re-shot, shot/collision clash.
module tb_ball_motion;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_tick = 1'b0;
    logic       shot_valid = 1'b0;
    logic       shot_ready;
    logic [9:0] shot_vx = '0, shot_vy = '0, shot_dx = '0, shot_dy = '0;
    logic       coll_in = 1'b0;
    logic [9:0] coll_vx = '0, coll_vy = '0, coll_dx = '0, coll_dy = '0;
    logic [9:0] x, y, vx, vy, dx, dy;
    logic       moving;

    int total = 0;
    int bad   = 0;

    localparam logic [9:0] P1 = 10'h001;
    localparam logic [9:0] M1 = 10'h3FF;

    ball_motion dut (
        .clk       (clk),
        .rst       (rst),
        .frame_tick(frame_tick),
        .shot_valid(shot_valid),
        .shot_ready(shot_ready),
        .shot_vx   (shot_vx),
        .shot_vy   (shot_vy),
        .shot_dx   (shot_dx),
        .shot_dy   (shot_dy),
        .coll_in   (coll_in),
        .coll_vx   (coll_vx),
        .coll_vy   (coll_vy),
        .coll_dx   (coll_dx),
        .coll_dy   (coll_dy),
        .x         (x),
        .y         (y),
        .vx        (vx),
        .vy        (vy),
        .dx        (dx),
        .dy        (dy),
        .moving    (moving)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic tick(input int n);
        frame_tick = 1'b1;
        repeat (n) cyc();
        frame_tick = 1'b0;
    endtask

    task automatic shot(input logic [9:0] svx, input logic [9:0] svy,
                        input logic [9:0] sdx, input logic [9:0] sdy);
        shot_vx = svx;
        shot_vy = svy;
        shot_dx = sdx;
        shot_dy = sdy;
        shot_valid = 1'b1;
        cyc();
        shot_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        cyc();
    endtask

    initial begin
        // Reset state
        repeat (2) cyc();
        chk("rst_x", x, 10'd100);
        chk("rst_y", y, 10'd200);
        chk("rst_vx", vx, 10'd0);
        chk("rst_vy", vy, 10'd0);
        chk("rst_dx", dx, P1);
        chk("rst_dy", dy, P1);
        chk("rst_moving", {9'd0, moving}, 10'd1 - 10'd1);
        chk("rst_ready", {9'd0, shot_ready}, 10'd1);
        rst = 1'b0;
        cyc();

        // Shot vx=4: 3 ticks -> 112, 8th tick -> 132 and friction to 3
        shot(10'd4, 10'd0, P1, P1);
        chk("shot_moving", {9'd0, moving}, 10'd1);
        chk("shot_vx", vx, 10'd4);
        tick(3);
        chk("t3_x", x, 10'd112);
        tick(5);
        chk("t8_x", x, 10'd132);
        chk("t8_vx", vx, 10'd3);
        chk("t8_y", y, 10'd200);

        // Asynchronous reset mid-motion
        rst = 1'b1;
        #2;
        chk("async_x", x, 10'd100);
        chk("async_vx", vx, 10'd0);
        chk("async_moving", {9'd0, moving}, 10'd0);
        cyc();
        rst = 1'b0;
        cyc();

        // Run vx=12 for 55 ticks: x = 100 + 8*(12+11+10+9+8+7) + 7*6 = 598, vx=6
        shot(10'd12, 10'd0, P1, P1);
        tick(55);
        chk("run_x", x, 10'd598);
        chk("run_vx", vx, 10'd6);

        // Collision together with frame_tick: load wins, position held
        coll_vx = 10'd6; coll_vy = 10'd0; coll_dx = P1; coll_dy = P1;
        coll_in = 1'b1; frame_tick = 1'b1;
        cyc();
        coll_in = 1'b0; frame_tick = 1'b0;
        chk("c1_x", x, 10'd598);
        chk("c1_vx", vx, 10'd6);
        chk("hold_ready", {9'd0, shot_ready}, 10'd0);
        tick(1);
        chk("pre_x", x, 10'd604);
        // 604+6=610 > 608 -> reflect to 606, dx=-1
        tick(1);
        chk("bounce_x", x, 10'd606);
        chk("bounce_dx", dx, M1);

        // Two more HOLD ticks with coll_in high: ignored
        coll_vx = 10'h3FB; coll_dx = M1; coll_in = 1'b1;
        tick(2);
        chk("ign_x", x, 10'd594);
        chk("ign_vx", vx, 10'd6);

        // Now in MOVE: collision -5/-1 with frame_tick -> vx=5, dx=-1, x held
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        chk("c2_vx", vx, 10'd5);
        chk("c2_dx", dx, M1);
        chk("c2_x", x, 10'd594);

        // Four ticks with coll_in still high are ignored, 5th is accepted
        coll_vx = 10'd9; coll_dx = P1;
        tick(4);
        chk("h4_x", x, 10'd574);
        chk("h4_vx", vx, 10'd5);
        chk("h4_dx", dx, M1);
        tick(1);
        coll_in = 1'b0;
        chk("c3_x", x, 10'd574);
        chk("c3_vx", vx, 10'd9);
        chk("c3_dx", dx, P1);

        // Friction to a stop: vx=1, vy=2, dy=-1 -> 16 ticks
        do_reset();
        shot(10'd1, 10'd2, P1, M1);
        tick(8);
        chk("f8_vx", vx, 10'd0);
        chk("f8_vy", vy, 10'd1);
        chk("f8_moving", {9'd0, moving}, 10'd1);
        tick(8);
        chk("f16_vx", vx, 10'd0);
        chk("f16_vy", vy, 10'd0);
        chk("f16_moving", {9'd0, moving}, 10'd0);
        chk("f16_ready", {9'd0, shot_ready}, 10'd1);
        chk("f16_dx", dx, P1);
        chk("f16_dy", dy, M1);
        chk("f16_x", x, 10'd108);
        chk("f16_y", y, 10'd176);
        // Saturating shot
        shot(10'd40, 10'd0, P1, P1);
        chk("sat_vx", vx, 10'd12);
        chk("sat_moving", {9'd0, moving}, 10'd1);

        // Shot and collision in the same IDLE cycle: collision wins
        do_reset();
        shot_vx = 10'd3; shot_vy = 10'd3; shot_dx = P1; shot_dy = P1; shot_valid = 1'b1;
        coll_vx = 10'd7; coll_vy = 10'd2; coll_dx = M1; coll_dy = P1; coll_in = 1'b1;
        #1;
        chk("clash_ready", {9'd0, shot_ready}, 10'd0);
        cyc();
        shot_valid = 1'b0;
        chk("clash_vx", vx, 10'd7);
        chk("clash_vy", vy, 10'd2);
        chk("clash_dx", dx, M1);
        chk("clash_moving", {9'd0, moving}, 10'd1);
        // Still HOLD: a further collision is ignored
        coll_vx = 10'd11;
        cyc();
        coll_in = 1'b0;
        chk("clash_hold_vx", vx, 10'd7);
        chk("clash_hold_ready", {9'd0, shot_ready}, 10'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ball_motion.md
# ball_motion

Per-ball kinematics stage for the billiard table: holds one ball's position, speed magnitude and direction, and advances the ball once per video frame. It applies cushion reflection and friction, accepts a cue shot, and loads post-impact velocity/direction from the ball-ball collision stage. Its x/y, vx/vy and dx/dy outputs feed that collision stage and the renderer. One instance exists per ball.

## Interface
Parameters:
- X_INIT, 100: reset x centre.
- Y_INIT, 200: reset y centre.
- BALL_R, 12: ball radius in pixels.
- XMIN / XMAX, 20 / 620: table x cushion limits.
- YMIN / YMAX, 20 / 460: table y cushion limits.
- VMAX, 12: speed saturation per axis; must satisfy VMAX ≤ BALL_R.
- FRIC_PERIOD, 8: frames per 1-unit speed decay.
- COLL_HOLD, 4: frames during which coll_in is ignored after a collision load.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- frame_tick  in  1  one-cycle pulse per frame.
- shot_valid  in  1  cue shot request.
- shot_ready  out  1  = (state==IDLE) & ~coll_in.
- shot_vx, shot_vy  in  10  speed magnitudes, unsigned.
- shot_dx, shot_dy  in  10  signed direction.
- coll_in  in  1  collision flag from the collision stage.
- coll_vx, coll_vy  in  10  signed new speeds; the value is treated as a magnitude.
- coll_dx, coll_dy  in  10  signed new directions.
- x, y  out  10  ball centre, registered.
- vx, vy  out  10  speed magnitude, 0..VMAX.
- dx, dy  out  10  signed, always +1 or -1.
- moving  out  1  1 unless in IDLE.

## Operation
- States:
  - IDLE: vx = vy = 0.
  - MOVE: advancing each frame.
  - HOLD: advancing each frame, coll_in ignored, hold_cnt counting down.
- Direction decode, applied to shot and collision inputs: bit 9 set gives -1; otherwise +1.
- Speed loads are saturated to VMAX. For collision loads, use the absolute value of the input first.
- Shot load:
  - Occurs when shot_valid & shot_ready.
  - Loads speeds and directions and clears fric_cnt.
  - Next state: MOVE if either speed ≠ 0, else stays IDLE.
- Collision load:
  - Occurs when coll_in is high in IDLE or MOVE.
  - Loads speeds and directions, clears fric_cnt, sets hold_cnt = COLL_HOLD, and moves to HOLD.
  - Collision has priority over a shot and over frame_tick in the same cycle; position is not advanced on that tick.
- Frame step: on frame_tick in MOVE or HOLD with no load that cycle, each axis is updated independently:
  - p_n = p + d·v, computed 11-bit signed.
  - If p_n > MAX-BALL_R: p = 2(MAX-BALL_R) - p_n, and d becomes -1.
  - If p_n < MIN+BALL_R: p = 2(MIN+BALL_R) - p_n, and d becomes +1.
  - Otherwise p = p_n.
- Friction:
  - On each frame step fric_cnt increments.
  - At FRIC_PERIOD-1 it wraps to 0, and every nonzero speed decrements by 1 in that same step. Speeds never go below 0.
- HOLD exit:
  - On each frame step in HOLD, hold_cnt decrements.
  - When it reaches 0, go to IDLE if both speeds are 0, else MOVE.
- MOVE exit: MOVE goes to IDLE when both speeds reach 0 after a step. dx and dy are retained.

## Timing
- Reset values:
  - x = X_INIT, y = Y_INIT.
  - vx = vy = 0, dx = dy = +1.
  - moving = 0, shot_ready = 1.
  - state IDLE, fric_cnt = hold_cnt = 0.
- rst asserted mid-motion forces all of the above immediately.
- All outputs except shot_ready are registered.
- A load or frame step is visible one cycle after the triggering edge.
- moving rises in the cycle after an accepted shot.
- shot_ready is combinational.

## Structure
- Shared package ball_pkg holds:
  - BALL_R, BALL_D = 24.
  - Table bounds.
  - VMAX.
  - DIR_POS / DIR_NEG constants.
  - The state enum (IDLE, MOVE, HOLD).
- Sub-module axis_step: one combinational instance per axis. It performs the position add, the reflection, the direction flip and the friction decrement.

## Test plan
- Reset → x = 100, y = 200, vx = vy = 0, dx = dy = +1, moving = 0, shot_ready = 1.
- Shot vx = 4, dx = +1, vy = 0 → after 3 ticks x = 112; after the 8th tick x = 132 and vx = 3.
- x = 604, vx = 6, dx = +1, XMAX = 620 → p_n = 610 > 608, so x = 606 and dx = -1.
- Collision and frame_tick in the same MOVE cycle, coll_vx = -5, coll_dx = -1 → vx = 5, dx = -1, x unchanged. coll_in is ignored for the next 4 ticks and accepted on the 5th.
- vx = 1, vy = 2, FRIC_PERIOD = 8 → after 16 ticks vx = vy = 0, moving = 0, shot_ready = 1, directions kept. A shot with vx = 40 then loads vx = 12.
- Shot and coll_in in the same IDLE cycle → shot_ready = 0, the collision values load, and the state is HOLD.
